// File: rtl/spi_xfer_seq_pkg.sv
// Shared types and SFR register map for the CoreSPI master-mode transfer sequencer.
package spi_xfer_seq_pkg;

  typedef enum logic [3:0] {
    S_IDLE,
    S_CFG,
    S_SSEL,
    S_EN,
    S_WAIT_TX,
    S_WR_TX,
    S_WAIT_RX,
    S_RD_RX,
    S_RD_ST,
    S_CLR,
    S_HOLD_RX,
    S_DIS,
    S_DESEL,
    S_FIN,
    S_ABORT
  } state_e;

  localparam logic [1:0] ADDR_DATA       = 2'b00;
  localparam logic [1:0] ADDR_CTRL       = 2'b01;
  localparam logic [1:0] ADDR_CTRL2_STAT = 2'b10;
  localparam logic [1:0] ADDR_SS         = 2'b11;

  localparam logic [7:0] CTRL2_ENABLE  = 8'h80;
  localparam logic [7:0] CTRL2_CLR_ERR = 8'h01;

  localparam int STAT_RXERR_BIT = 0;

endpackage

// File: rtl/spi_xfer_seq_wdog.sv
// Receive watchdog: counts cycles while enabled and flags the last allowed cycle.
module spi_xfer_seq_wdog #(
  parameter int TIMEOUT_CYCLES = 4096,
  parameter int TO_W           = 12
) (
  input  logic sysclk,
  input  logic nreset,
  input  logic clr_i,
  input  logic en_i,
  output logic expired_o
);

  localparam logic [TO_W-1:0] LAST = TO_W'(TIMEOUT_CYCLES - 1);

  logic [TO_W-1:0] cnt_q, cnt_d;

  assign expired_o = (cnt_q == LAST);

  // Saturates at LAST so a lingering enable can never wrap back to a fresh window.
  always_comb begin
    cnt_d = cnt_q;
    if (clr_i) begin
      cnt_d = '0;
    end else if (en_i && !expired_o) begin
      cnt_d = cnt_q + TO_W'(1);
    end
  end

  always_ff @(posedge sysclk or negedge nreset) begin
    if (!nreset) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

endmodule

// File: rtl/spi_xfer_seq.sv
// Drives the CoreSPI SFR bus through one multi-byte master transaction per start pulse.
// Optional receive-status check: define SPI_XFER_SEQ_ERRCHK_EN.
module spi_xfer_seq
  import spi_xfer_seq_pkg::*;
#(
  parameter int TIMEOUT_CYCLES = 4096,
  parameter int TO_W           = 12
) (
  input  logic       sysclk,
  input  logic       nreset,
  input  logic       start_i,
  input  logic [7:0] xfer_len_i,
  input  logic [7:0] ctrl_cfg_i,
  input  logic [7:0] ss_mask_i,
  output logic       busy_o,
  output logic       done_o,
  output logic       err_o,
  input  logic       tx_valid_i,
  input  logic [7:0] tx_data_i,
  output logic       tx_ready_o,
  output logic       rx_valid_o,
  output logic [7:0] rx_data_o,
  input  logic       rx_ready_i,
  output logic [7:0] sfr_wdata_o,
  input  logic [7:0] sfr_rdata_i,
  output logic [1:0] sfr_addr_o,
  output logic       sfr_we_o,
  output logic       sfr_re_o,
  input  logic       sfr_tx_empty_i,
  input  logic       sfr_rx_ready_i
);

  state_e     state_q, state_d;
  logic [7:0] cnt_q, cnt_d;
  logic       rxv_q, rxv_d;
  logic [7:0] rxd_q, rxd_d;
  logic       err_q, err_d;
  logic       zdone_q, zdone_d;
  logic       first_q, first_d;
  logic       wd_clr, wd_en, wd_expired;

  spi_xfer_seq_wdog #(
    .TIMEOUT_CYCLES(TIMEOUT_CYCLES),
    .TO_W          (TO_W)
  ) u_wdog (
    .sysclk   (sysclk),
    .nreset   (nreset),
    .clr_i    (wd_clr),
    .en_i     (wd_en),
    .expired_o(wd_expired)
  );

  // A zero-length start finishes from IDLE via zdone_q, so it also counts as busy.
  assign busy_o     = (state_q != S_IDLE) || zdone_q;
  assign done_o     = (state_q == S_FIN) || zdone_q;
  assign err_o      = err_q;
  assign rx_valid_o = rxv_q;
  assign rx_data_o  = rxd_q;

  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    rxv_d       = rxv_q;
    rxd_d       = rxd_q;
    err_d       = err_q;
    zdone_d     = 1'b0;
    first_d     = 1'b0;
    sfr_we_o    = 1'b0;
    sfr_re_o    = 1'b0;
    sfr_addr_o  = ADDR_DATA;
    sfr_wdata_o = 8'h00;
    tx_ready_o  = 1'b0;
    wd_clr      = 1'b0;
    wd_en       = 1'b0;

    case (state_q)
      S_IDLE: begin
        if (start_i && !zdone_q) begin
          err_d = 1'b0;
          if (xfer_len_i == 8'd0) begin
            zdone_d = 1'b1;
          end else begin
            cnt_d   = xfer_len_i;
            state_d = S_CFG;
          end
        end
      end
      S_CFG: begin
        sfr_we_o    = 1'b1;
        sfr_addr_o  = ADDR_CTRL;
        sfr_wdata_o = ctrl_cfg_i;
        state_d     = S_SSEL;
      end
      S_SSEL: begin
        sfr_we_o    = 1'b1;
        sfr_addr_o  = ADDR_SS;
        sfr_wdata_o = ss_mask_i;
        state_d     = S_EN;
      end
      S_EN: begin
        sfr_we_o    = 1'b1;
        sfr_addr_o  = ADDR_CTRL2_STAT;
        sfr_wdata_o = CTRL2_ENABLE;
        state_d     = S_WAIT_TX;
      end
      S_WAIT_TX: begin
        if (tx_valid_i && sfr_tx_empty_i) state_d = S_WR_TX;
      end
      S_WR_TX: begin
        sfr_we_o    = 1'b1;
        sfr_addr_o  = ADDR_DATA;
        sfr_wdata_o = tx_data_i;
        tx_ready_o  = 1'b1;
        wd_clr      = 1'b1;
        first_d     = 1'b1;
        state_d     = S_WAIT_RX;
      end
      S_WAIT_RX: begin
        // The SFR's rx_data_ready may still reflect the previous byte on the first cycle.
        wd_en = 1'b1;
        if (!first_q && sfr_rx_ready_i) begin
          state_d = S_RD_RX;
        end else if (wd_expired) begin
          state_d = S_ABORT;
        end
      end
      S_RD_RX: begin
        sfr_re_o   = 1'b1;
        sfr_addr_o = ADDR_DATA;
        rxd_d      = sfr_rdata_i;
`ifdef SPI_XFER_SEQ_ERRCHK_EN
        state_d    = S_RD_ST;
`else
        rxv_d      = 1'b1;
        state_d    = S_HOLD_RX;
`endif
      end
`ifdef SPI_XFER_SEQ_ERRCHK_EN
      S_RD_ST: begin
        sfr_re_o   = 1'b1;
        sfr_addr_o = ADDR_CTRL2_STAT;
        if (sfr_rdata_i[STAT_RXERR_BIT]) begin
          state_d = S_CLR;
        end else begin
          rxv_d   = 1'b1;
          state_d = S_HOLD_RX;
        end
      end
      S_CLR: begin
        sfr_we_o    = 1'b1;
        sfr_addr_o  = ADDR_CTRL2_STAT;
        sfr_wdata_o = CTRL2_ENABLE | CTRL2_CLR_ERR;
        state_d     = S_ABORT;
      end
`endif
      S_HOLD_RX: begin
        if (rxv_q && rx_ready_i) begin
          rxv_d   = 1'b0;
          cnt_d   = cnt_q - 8'd1;
          state_d = (cnt_q == 8'd1) ? S_DIS : S_WAIT_TX;
        end
      end
      S_DIS: begin
        sfr_we_o    = 1'b1;
        sfr_addr_o  = ADDR_CTRL2_STAT;
        sfr_wdata_o = 8'h00;
        state_d     = S_DESEL;
      end
      S_DESEL: begin
        sfr_we_o    = 1'b1;
        sfr_addr_o  = ADDR_SS;
        sfr_wdata_o = 8'h00;
        state_d     = S_FIN;
      end
      S_FIN: begin
        state_d = S_IDLE;
      end
      S_ABORT: begin
        err_d   = 1'b1;
        state_d = S_DIS;
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  always_ff @(posedge sysclk or negedge nreset) begin
    if (!nreset) begin
      state_q <= S_IDLE;
      cnt_q   <= 8'd0;
      rxv_q   <= 1'b0;
      rxd_q   <= 8'd0;
      err_q   <= 1'b0;
      zdone_q <= 1'b0;
      first_q <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      rxv_q   <= rxv_d;
      rxd_q   <= rxd_d;
      err_q   <= err_d;
      zdone_q <= zdone_d;
      first_q <= first_d;
    end
  end

endmodule

// File: tb/tb_spi_xfer_seq.sv
// Randomized bench for spi_xfer_seq against a loopback CoreSPI SFR model and transaction-level expectations.
module tb_spi_xfer_seq;

  localparam int TO_CYC = 16;

  logic       sysclk = 1'b0;
  logic       nreset = 1'b0;
  logic       start_i = 1'b0;
  logic [7:0] xfer_len_i = 8'd0;
  logic [7:0] ctrl_cfg_i = 8'd0;
  logic [7:0] ss_mask_i = 8'd0;
  logic       busy_o, done_o, err_o;
  logic       tx_valid_i, tx_ready_o;
  logic [7:0] tx_data_i;
  logic       rx_valid_o, rx_ready_i;
  logic [7:0] rx_data_o;
  logic [7:0] sfr_wdata_o, sfr_rdata_i;
  logic [1:0] sfr_addr_o;
  logic       sfr_we_o, sfr_re_o;
  logic       sfr_tx_empty_i, sfr_rx_ready_i;

  always #5 sysclk = ~sysclk;

  spi_xfer_seq #(.TIMEOUT_CYCLES(TO_CYC), .TO_W(4)) dut (
    .sysclk        (sysclk),
    .nreset        (nreset),
    .start_i       (start_i),
    .xfer_len_i    (xfer_len_i),
    .ctrl_cfg_i    (ctrl_cfg_i),
    .ss_mask_i     (ss_mask_i),
    .busy_o        (busy_o),
    .done_o        (done_o),
    .err_o         (err_o),
    .tx_valid_i    (tx_valid_i),
    .tx_data_i     (tx_data_i),
    .tx_ready_o    (tx_ready_o),
    .rx_valid_o    (rx_valid_o),
    .rx_data_o     (rx_data_o),
    .rx_ready_i    (rx_ready_i),
    .sfr_wdata_o   (sfr_wdata_o),
    .sfr_rdata_i   (sfr_rdata_i),
    .sfr_addr_o    (sfr_addr_o),
    .sfr_we_o      (sfr_we_o),
    .sfr_re_o      (sfr_re_o),
    .sfr_tx_empty_i(sfr_tx_empty_i),
    .sfr_rx_ready_i(sfr_rx_ready_i)
  );

  int checks = 0;
  int errors = 0;

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  // Environment state shared between the SFR/stream model and the scenario sequencer.
  logic [7:0] txq[$];
  logic [9:0] wlog[$];
  int         wcyc[$];
  logic [7:0] rxlog[$];
  bit         tx_stall = 0;
  bit         norx = 0;
  int         rx_mode = 0;
  int         cyc = 0, done_cnt = 0, done_cyc = 0, re_cnt = 0;
  int         tx_pops = 0, addr0_writes = 0, last_a0_cyc = 0, st_cyc = 0;
  bit         shifting = 0;
  int         shift_cnt = 0;
  logic [7:0] shift_byte = 8'd0, rx_buf = 8'd0;
  logic       prev_rxv = 1'b0, prev_rxr = 1'b0;
  logic [7:0] prev_rxd = 8'd0;

  assign sfr_rdata_i = (sfr_addr_o == 2'b00) ? rx_buf : 8'h00;

  // SFR loopback model plus TX/RX stream endpoints, all evaluated on the falling edge.
  initial begin
    tx_valid_i = 1'b0; tx_data_i = 8'd0; rx_ready_i = 1'b0;
    sfr_tx_empty_i = 1'b1; sfr_rx_ready_i = 1'b0;
    forever begin
      @(negedge sysclk);
      cyc++;
      if (!nreset) begin
        shifting = 0; sfr_tx_empty_i = 1'b1; sfr_rx_ready_i = 1'b0; rx_buf = 8'd0;
        prev_rxv = 1'b0; prev_rxr = 1'b0;
      end else begin
        chk("we_re_excl", sfr_we_o & sfr_re_o, 1'b0);
        if (sfr_we_o) begin
          wlog.push_back({sfr_addr_o, sfr_wdata_o});
          wcyc.push_back(cyc);
        end
        if (sfr_re_o) re_cnt++;
        if (tx_ready_o) begin
          chk("txr_bus", {tx_valid_i, sfr_we_o, sfr_addr_o, sfr_wdata_o},
              {1'b1, 1'b1, 2'b00, tx_data_i});
          if (txq.size() > 0) void'(txq.pop_front());
          tx_pops++;
        end
        if (sfr_re_o && sfr_addr_o == 2'b00) sfr_rx_ready_i = 1'b0;
        if (sfr_we_o && sfr_addr_o == 2'b00) begin
          chk("tx_while_rx_pending", rx_valid_o, 1'b0);
          shifting = 1; shift_cnt = $urandom_range(2, 6); shift_byte = sfr_wdata_o;
          sfr_tx_empty_i = 1'b0; addr0_writes++; last_a0_cyc = cyc;
        end else if (shifting) begin
          shift_cnt--;
          if (shift_cnt == 0) begin
            shifting = 0; sfr_tx_empty_i = 1'b1;
            if (!norx) begin rx_buf = shift_byte; sfr_rx_ready_i = 1'b1; end
          end
        end
        if (prev_rxv && !prev_rxr && rx_valid_o) chk("rx_hold_data", rx_data_o, prev_rxd);
        if (rx_mode == 2 && prev_rxv && prev_rxr) chk("rx_accept_1cyc", rx_valid_o, 1'b0);
        if (done_o) begin done_cnt++; done_cyc = cyc; end
      end
      tx_valid_i = nreset && (txq.size() > 0) && !tx_stall;
      tx_data_i  = (txq.size() > 0) ? txq[0] : 8'h00;
      rx_ready_i = (rx_mode == 0) ? 1'($urandom_range(0, 1)) : (rx_mode == 2);
      if (nreset && rx_valid_o && rx_ready_i) rxlog.push_back(rx_data_o);
      prev_rxv = rx_valid_o; prev_rxd = rx_data_o; prev_rxr = rx_ready_i;
    end
  end

  task automatic clear_logs();
    wlog.delete(); wcyc.delete(); rxlog.delete();
    done_cnt = 0; re_cnt = 0;
  endtask

  task automatic start_xfer(input int len, input logic [7:0] cfg, input logic [7:0] mask);
    @(negedge sysclk); #1;
    ctrl_cfg_i = cfg; ss_mask_i = mask; xfer_len_i = 8'(len); start_i = 1'b1; st_cyc = cyc;
    @(negedge sysclk); #1;
    start_i = 1'b0;
  endtask

  task automatic wait_done(input string tag, input int maxc);
    int n = 0;
    while (done_cnt == 0 && n < maxc) begin @(negedge sysclk); #1; n++; end
    chk({tag, "_done_seen"}, done_cnt > 0, 1'b1);
  endtask

  // One transaction; the expected bus trace and RX stream come from the transfer rules alone.
  task automatic run_xfer(input string tag, input logic [7:0] b[$], input logic [7:0] cfg,
                          input logic [7:0] mask, input bit stall, input int rxm, input bit no_rx);
    logic [9:0] exp[$];
    int n, a0;
    clear_logs();
    txq = b; norx = no_rx; rx_mode = rxm;
    start_xfer(b.size(), cfg, mask);
    chk({tag, "_start_lat"}, (wcyc.size() > 0) ? wcyc[0] - st_cyc : -1, 1);
    chk({tag, "_busy"}, busy_o, 1'b1);
    if (stall) begin
      n = 0;
      while (tx_pops == 0 && n < 200) begin @(negedge sysclk); #1; n++; end
      tx_stall = 1;
      start_i = 1'b1; xfer_len_i = 8'd0;
      @(negedge sysclk); #1;
      start_i = 1'b0;
      repeat (50) @(negedge sysclk);
      #1;
      chk({tag, "_stall_busy"}, busy_o, 1'b1);
      chk({tag, "_stall_err"}, err_o, 1'b0);
      tx_stall = 0;
    end
    if (rxm == 1) begin
      n = 0;
      while (!rx_valid_o && n < 200) begin @(negedge sysclk); #1; n++; end
      a0 = addr0_writes;
      repeat (100) @(negedge sysclk);
      #1;
      chk({tag, "_hold_rxv"}, rx_valid_o, 1'b1);
      chk({tag, "_hold_notx"}, addr0_writes, a0);
      rx_mode = 0;
    end
    wait_done(tag, 200 + 40 * b.size());
    repeat (3) @(negedge sysclk);
    #1;
    chk({tag, "_done_cnt"}, done_cnt, 1);
    chk({tag, "_err"}, err_o, no_rx);
    chk({tag, "_idle"}, busy_o, 1'b0);
    exp = '{{2'b01, cfg}, {2'b11, mask}, {2'b10, 8'h80}};
    for (int i = 0; i < (no_rx ? 1 : b.size()); i++) exp.push_back({2'b00, b[i]});
    exp.push_back({2'b10, 8'h00});
    exp.push_back({2'b11, 8'h00});
    chk({tag, "_wr_cnt"}, wlog.size(), exp.size());
    for (int i = 0; i < exp.size() && i < wlog.size(); i++)
      chk($sformatf("%s_wr%0d", tag, i), wlog[i], exp[i]);
    chk({tag, "_rx_cnt"}, rxlog.size(), no_rx ? 0 : b.size());
    for (int i = 0; i < rxlog.size() && i < b.size(); i++)
      chk($sformatf("%s_rx%0d", tag, i), rxlog[i], b[i]);
    if (no_rx) chk({tag, "_abort_time"}, done_cyc - last_a0_cyc, TO_CYC + 4);
    txq.delete(); norx = 0; rx_mode = 0;
  endtask

  logic [7:0] bytes[$];

  task automatic rand_bytes(input int len);
    bytes.delete();
    for (int i = 0; i < len; i++) bytes.push_back(8'($urandom));
  endtask

  initial begin
    repeat (3) @(negedge sysclk);
    #1;
    chk("rst_outputs", {busy_o, done_o, err_o, tx_ready_o, rx_valid_o, rx_data_o,
                        sfr_wdata_o, sfr_addr_o, sfr_we_o, sfr_re_o}, '0);
    nreset = 1'b1;
    repeat (2) @(negedge sysclk);

    bytes = '{8'hA5, 8'h3C, 8'hFF};
    run_xfer("basic", bytes, 8'hC0, 8'h01, 0, 0, 0);

    clear_logs();
    start_xfer(0, 8'hC0, 8'h01);
    repeat (3) @(negedge sysclk);
    #1;
    chk("len0_done_cnt", done_cnt, 1);
    chk("len0_done_lat", done_cyc - st_cyc, 1);
    chk("len0_no_we", wlog.size(), 0);
    chk("len0_no_re", re_cnt, 0);

    rand_bytes(4);
    run_xfer("stall", bytes, 8'h40 | 8'($urandom_range(0, 63)), 8'($urandom), 1, 0, 0);
    rand_bytes(3);
    run_xfer("rxhold", bytes, 8'hC4, 8'h02, 0, 1, 0);
    rand_bytes(5);
    run_xfer("rxhigh", bytes, 8'hC8, 8'h04, 0, 2, 0);
    rand_bytes(2);
    run_xfer("timeout", bytes, 8'hC0, 8'h01, 0, 0, 1);
    rand_bytes(2);
    run_xfer("after_abort", bytes, 8'hC0, 8'h08, 0, 0, 0);
    rand_bytes(255);
    run_xfer("len255", bytes, 8'hC2, 8'h80, 0, 0, 0);

    begin
      int n = 0;
      int a0;
      clear_logs();
      rand_bytes(4);
      txq = bytes;
      a0 = addr0_writes;
      start_xfer(4, 8'hC0, 8'h01);
      while (addr0_writes < a0 + 2 && n < 400) begin @(negedge sysclk); #1; n++; end
      chk("rst_mid_reached", addr0_writes - a0, 2);
      @(posedge sysclk); #1;
      nreset = 1'b0;
      #1;
      chk("rst_mid_outputs", {busy_o, done_o, err_o, tx_ready_o, rx_valid_o, rx_data_o,
                              sfr_wdata_o, sfr_addr_o, sfr_we_o, sfr_re_o}, '0);
      txq.delete();
      @(negedge sysclk); #1;
      nreset = 1'b1;
      @(negedge sysclk); #1;
      chk("rst_mid_idle", busy_o, 1'b0);
    end
    rand_bytes(1);
    run_xfer("post_rst", bytes, 8'hC0, 8'h01, 0, 0, 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #900000;
    $display("FAIL global_timeout got=running exp=finished");
    $fatal(1, "bench time limit exceeded");
  end

endmodule

// File: doc/spi_xfer_seq.md
Name: spi_xfer_seq

Overview:
- Upstream sequencer for the CoreSPI SFR block in master mode. It drives the SFR's microcontroller bus (data_in/data_out/addrbus/we/re) so that the CPU does not have to.
- Runs one multi-byte SPI transaction per start pulse: configure, select slave, enable, then per byte write TX / wait / read RX, then disable.
- Byte streams use valid/ready handshakes on both sides. One byte is in flight at a time.

Parameters:
- TIMEOUT_CYCLES, 4096, maximum sysclk cycles spent in WAIT_RX before the transfer aborts (power of 2, at least 16).
- TO_W, 12, width of the timeout counter (log2 of TIMEOUT_CYCLES).

Ports:
- sysclk  in  1  clock
- nreset  in  1  asynchronous, active-low reset
- start  in  1  one-cycle pulse; sampled only in IDLE
- xfer_len  in  8  number of bytes; sampled on start; 0 means no transfer
- ctrl_cfg  in  8  value written to the SFR control register (bit6 must be 1 for master)
- ss_mask  in  8  value written to the SFR slave-select register
- busy  out  1  high from the cycle after an accepted start until done
- done  out  1  one-cycle pulse at the end of a transfer (normal or aborted)
- err  out  1  sticky abort flag; cleared by the next accepted start
- tx_valid / tx_data[8] / tx_ready  in / in / out  TX byte stream (tx_ready is a 1-cycle accept)
- rx_valid / rx_data[8] / rx_ready  out / out / in  RX byte stream
- sfr_wdata  out  8  to SFR data_in
- sfr_rdata  in  8  from SFR data_out (combinational response to re)
- sfr_addr  out  2  to SFR addrbus
- sfr_we, sfr_re  out  1 each
- sfr_tx_empty, sfr_rx_ready  in  1 each  from SFR tx_reg_empty / rx_data_ready

Behaviour:
- Reset values: all outputs 0, state IDLE, byte counter 0, timeout counter 0, err 0.
- Bus ops: every SFR access is a single registered cycle. At most one of sfr_we/sfr_re is high in a cycle. sfr_rdata is captured in the same cycle sfr_re is high.
- FSM states and transitions:
  - IDLE: on start with xfer_len=0, pulse done the next cycle and make no SFR access. On start with xfer_len>0, latch xfer_len into the counter and go to CFG.
  - CFG: write addr 01 = ctrl_cfg. Then SSEL.
  - SSEL: write addr 11 = ss_mask. Then EN.
  - EN: write addr 10 = 0x80. Then WAIT_TX.
  - WAIT_TX: stay until tx_valid & sfr_tx_empty. No timeout here; upstream stalls are unbounded.
  - WR_TX: write addr 00 = tx_data and pulse tx_ready in the same cycle. Clear the timeout counter. Then WAIT_RX.
  - WAIT_RX: ignore sfr_rx_ready in the first cycle after WR_TX. After that, sfr_rx_ready leads to RD_RX. If the timeout counter reaches TIMEOUT_CYCLES-1, go to ABORT.
  - RD_RX: sfr_re at addr 00; capture the byte into rx_data; set rx_valid. Then HOLD_RX.
  - HOLD_RX: hold rx_valid/rx_data stable until rx_ready. On rx_valid & rx_ready: clear rx_valid and decrement the counter. Counter now 0 leads to DIS; otherwise WAIT_TX.
  - DIS: write addr 10 = 0x00. Then DESEL.
  - DESEL: write addr 11 = 0x00. Then FIN.
  - FIN: pulse done. Then IDLE.
  - ABORT: set err and go to DIS.
- Latency: start to first SFR write is 1 cycle. The minimum per-byte overhead beyond the SPI shift is 4 cycles.
- Boundaries:
  - start while busy is ignored.
  - xfer_len=255 is legal (8-bit counter, no wrap).
  - rx_ready held high beforehand is accepted in the first HOLD_RX cycle.
  - tx_ready is never asserted outside WR_TX.
  - An nreset assertion mid-transfer returns every state to reset immediately; the SFR shares nreset.

Optional Feature:
- Macro SPI_XFER_SEQ_ERRCHK_EN.
- When defined, RD_RX is followed by RD_ST: sfr_re at addr 10.
  - If captured status bit0 (rx_error) is 1: go to CLR, which writes addr 10 = 0x81 (clear_error, enable kept). Then ABORT. The received byte is discarded; rx_valid is not raised.
  - Otherwise rx_valid is raised and the flow continues to HOLD_RX.
- When undefined: no status read; err is set only by timeout.

Decomposition:
- Package spi_xfer_seq_pkg holds:
  - the state enum;
  - SFR address constants ADDR_DATA=2'b00, ADDR_CTRL=2'b01, ADDR_CTRL2_STAT=2'b10, ADDR_SS=2'b11;
  - CTRL2_ENABLE=8'h80, CTRL2_CLR_ERR=8'h01;
  - STAT_RXERR_BIT=0.
- Sub-module spi_xfer_seq_wdog: a TO_W-bit timeout counter with clear/enable inputs and an expired output.

Test Plan:
- ctrl_cfg=0xC0, ss_mask=0x01, len=3, TX bytes A5,3C,FF, SFR with MISO looped to MOSI -> RX 0xA5,0x3C,0xFF in order; bus write sequence 01:C0, 11:01, 10:80, then 10:00 and 11:00; exactly one done; err=0.
- len=0 -> done 1 cycle after start; no sfr_we/sfr_re ever asserted.
- tx_valid low for 50 cycles mid-transfer -> stays in WAIT_TX, no timeout, no err; completes after tx_valid rises.
- rx_ready held low for 100 cycles -> rx_data stable and no further TX write until accepted.
- sfr_rx_ready forced 0 with TIMEOUT_CYCLES=16 -> abort after 16 cycles in WAIT_RX; err=1; disable and deselect writes issued; done pulses once.
- nreset pulsed during WAIT_RX of byte 2 of 4 -> all outputs 0; a new start then completes a 1-byte transfer normally.
